// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if -- request/accept handshake between a data source and the
// UART transmit controller.
//   tx_data_i  : word to transmit (DATA_BITS wide), source -> controller
//   tx_valid_i : source has a word pending,          source -> controller
//   tx_ready_o : controller can accept a word,       controller -> source
// Signal names keep the controller-side port names of the flat version.
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;

  modport master (
    output tx_data_i,
    output tx_valid_i,
    input  tx_ready_o
  );

  modport slave (
    input  tx_data_i,
    input  tx_valid_i,
    output tx_ready_o
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmitter: one start bit, DATA_BITS data bits sent
// LSB first, STOP_BITS stop bits, each bit CLKS_PER_BIT clocks long.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : handshake (tx_data_i, tx_valid_i in; tx_ready_o out)
//   tx_o    : serial line, idle high, driven from a flop
//   busy_o  : frame in progress
//   done_o  : one-cycle pulse in the first idle cycle after a frame
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  uart_tx_ctrl_if.slave  bus,
  output logic           tx_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int BW  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BCW = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e               state_q;
  logic [BW-1:0]        baud_q;
  logic [BW-1:0]        baud_d;
  logic [BCW-1:0]       bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 tick;

  // Baud counter wraps to zero on the bit-end tick.
  always_comb begin
    tick   = (baud_q == BAUD_LAST);
    baud_d = tick ? '0 : baud_q + 1'b1;
  end

  // All outputs are registered; tx_q is loaded with the level of the bit
  // that starts after each edge, so the line never sees combinational logic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.tx_valid_i && ready_q) begin
            shift_q <= bus.tx_data_i;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          baud_q <= baud_d;
          if (tick) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          baud_q <= baud_d;
          if (tick) begin
            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              // bit counter is reused to count stop bits
              bit_q   <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
              // next data bit is the one about to reach position 0
              tx_q  <= shift_q[1];
            end
          end
        end
        STOP: begin
          baud_q <= baud_d;
          if (tick) begin
            if (bit_q == STOP_LAST) begin
              bit_q   <= '0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready_o = ready_q;
  assign tx_o           = tx_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  localparam int CPB = 4;

  logic clk = 1'b0;
  bit   clk_en = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  uart_tx_ctrl_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) bus2 ();

  logic tx1, busy1, done1;
  logic tx2, busy2, done2;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus1.slave),
    .tx_o   (tx1),
    .busy_o (busy1),
    .done_o (done1)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus2.slave),
    .tx_o   (tx2),
    .busy_o (busy2),
    .done_o (done2)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_tx(input logic [7:0] d, input int c);
    if (c <= CPB) return 1'b0;
    if (c <= 9 * CPB) return d[(c - CPB - 1) / CPB];
    return 1'b1;
  endfunction

  // Entered at the sample point of cycle 1 after the accepting edge; leaves
  // at the sample point of the done cycle.
  task automatic check_frame(input bit sel, input logic [7:0] d,
                             input int stop_bits, input string name);
    int   len;
    logic otx, obusy, odone, ordy;
    logic etx, edone;
    len = (1 + 8 + stop_bits) * CPB;
    for (int c = 1; c <= len + 1; c++) begin
      otx   = sel ? tx2 : tx1;
      obusy = sel ? busy2 : busy1;
      odone = sel ? done2 : done1;
      ordy  = sel ? bus2.tx_ready_o : bus1.tx_ready_o;
      etx   = (c == len + 1) ? 1'b1 : exp_tx(d, c);
      edone = (c == len + 1);
      checks += 4;
      if (otx !== etx) begin
        errors++;
        $display("FAIL %s tx cycle %0d: got %b expected %b", name, c, otx, etx);
      end
      if (odone !== edone) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b expected %b", name, c, odone, edone);
      end
      if (ordy !== edone) begin
        errors++;
        $display("FAIL %s ready cycle %0d: got %b expected %b", name, c, ordy, edone);
      end
      if (obusy !== !edone) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, obusy, !edone);
      end
      if (c <= len) step();
    end
  endtask

  task automatic check_done_clears(input bit sel, input string name);
    logic odone;
    step();
    odone = sel ? done2 : done1;
    checks++;
    if (odone !== 1'b0) begin
      errors++;
      $display("FAIL %s done_second_cycle: got %b expected 0", name, odone);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks += 5;
    if (tx1 !== 1'b1) begin errors++; $display("FAIL %s tx: got %b expected 1", name, tx1); end
    if (bus1.tx_ready_o !== 1'b1) begin errors++; $display("FAIL %s ready: got %b expected 1", name, bus1.tx_ready_o); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", name, busy1); end
    if (done1 !== 1'b0) begin errors++; $display("FAIL %s done: got %b expected 0", name, done1); end
    if (tx2 !== 1'b1) begin errors++; $display("FAIL %s tx2: got %b expected 1", name, tx2); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus1.tx_valid_i = 1'b0; bus1.tx_data_i = '0;
    bus2.tx_valid_i = 1'b0; bus2.tx_data_i = '0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_clk_stopped");
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_clk_running");
    rst_n = 1'b1;
    step();
    check_reset_outputs("idle_after_release");
  endtask

  task automatic test_send_a5();
    bus1.tx_data_i = 8'hA5; bus1.tx_valid_i = 1'b1;
    step();
    bus1.tx_valid_i = 1'b0;
    check_frame(1'b0, 8'hA5, 1, "a5");
    check_done_clears(1'b0, "a5");
  endtask

  task automatic test_ignore_while_busy();
    bus1.tx_data_i = 8'h3C; bus1.tx_valid_i = 1'b1;
    step();
    bus1.tx_data_i = 8'hFF;
    check_frame(1'b0, 8'h3C, 1, "3c_ignore");
    step();
    bus1.tx_valid_i = 1'b0;
    check_frame(1'b0, 8'hFF, 1, "ff_after_3c");
    check_done_clears(1'b0, "ff_after_3c");
  endtask

  task automatic test_back_to_back();
    bus1.tx_data_i = 8'h00; bus1.tx_valid_i = 1'b1;
    step();
    bus1.tx_data_i = 8'hFF;
    check_frame(1'b0, 8'h00, 1, "b2b_00");
    step();
    bus1.tx_valid_i = 1'b0;
    check_frame(1'b0, 8'hFF, 1, "b2b_ff");
    check_done_clears(1'b0, "b2b_ff");
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    bus1.tx_data_i = 8'h55; bus1.tx_valid_i = 1'b1;
    step();
    bus1.tx_valid_i = 1'b0;
    repeat (13) step();
    checks++;
    if (tx1 !== 1'b1 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_bit2: got tx %b busy %b expected tx 1 busy 1", tx1, busy1);
    end
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_frame");
    step();
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (done1 !== 1'b0 || tx1 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_done_after_abort: got %0d bad cycles expected 0", bad);
    end
    bus1.tx_data_i = 8'h81; bus1.tx_valid_i = 1'b1;
    step();
    bus1.tx_valid_i = 1'b0;
    check_frame(1'b0, 8'h81, 1, "81_after_reset");
    check_done_clears(1'b0, "81_after_reset");
  endtask

  task automatic test_two_stop_bits();
    int stop_run;
    bus2.tx_data_i = 8'hF0; bus2.tx_valid_i = 1'b1;
    step();
    bus2.tx_valid_i = 1'b0;
    // count the stop-level run independently of the full-frame check
    repeat (36) step();
    stop_run = 0;
    while (tx2 === 1'b1 && busy2 === 1'b1 && stop_run < 20) begin
      stop_run++;
      step();
    end
    checks++;
    if (stop_run != 8) begin
      errors++;
      $display("FAIL stop2_run: got %0d cycles expected 8", stop_run);
    end
    repeat (4) step();
    bus2.tx_data_i = 8'hF0; bus2.tx_valid_i = 1'b1;
    step();
    bus2.tx_valid_i = 1'b0;
    check_frame(1'b1, 8'hF0, 2, "f0_stop2");
    check_done_clears(1'b1, "f0_stop2");
  endtask

  initial begin
    test_reset();
    test_send_a5();
    repeat (3) step();
    test_ignore_while_busy();
    repeat (3) step();
    test_back_to_back();
    repeat (3) step();
    test_reset_mid_frame();
    repeat (3) step();
    test_two_stop_bits();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 The block SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_ni  input  1  reset; reset is asynchronous and active-low.
REQ-006 The block SHALL have port tx_data_i  input  DATA_BITS  byte to transmit, sampled only on acceptance.
REQ-007 The block SHALL have port tx_valid_i  input  1  requester has data.
REQ-008 The block SHALL have port tx_ready_o  output  1  controller can accept data.
REQ-009 The block SHALL have port tx_o  output  1  serial line, idle high.
REQ-010 The block SHALL have port busy_o  output  1  frame in progress.
REQ-011 The block SHALL have port done_o  output  1  one-cycle pulse at frame completion.

Function
REQ-012 The block SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 The block SHALL accept a request when tx_valid_i && tx_ready_o at a rising edge; tx_ready_o = 1 only in IDLE.
REQ-014 On acceptance the block SHALL latch tx_data_i into a shift register, clear the baud and bit counters, and enter START on the same edge.
REQ-015 The block SHALL change tx_o from 1 to 0 in the first cycle after the accepting edge (latency 1 cycle).
REQ-016 The baud counter SHALL count 0..CLKS_PER_BIT-1 and produce a bit-end tick at terminal count, then wrap to 0.
REQ-017 START SHALL drive tx_o = 0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-018 DATA SHALL drive tx_o = shift-register bit 0 (LSB first); at each bit-end tick the register shifts right and the bit counter increments.
REQ-019 After the DATA_BITS-th bit-end tick, DATA SHALL enter STOP; the bit counter is sized to hold DATA_BITS without overflow.
REQ-020 STOP SHALL drive tx_o = 1 for STOP_BITS*CLKS_PER_BIT cycles, then enter IDLE.
REQ-021 The block SHALL assert done_o for exactly one cycle, namely the first cycle in IDLE after STOP.
REQ-022 A full frame SHALL occupy (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles of tx_o.
REQ-023 busy_o SHALL equal 1 in START, DATA and STOP, and 0 in IDLE.
REQ-024 While not IDLE, tx_valid_i and tx_data_i SHALL be ignored, and changes to tx_data_i after acceptance SHALL NOT affect tx_o.
REQ-025 Back-to-back frames: a request held high SHALL be accepted in the done_o cycle, giving exactly one idle-high cycle between the stop bit and the next start bit.
REQ-026 tx_o SHALL be driven from a flop, glitch-free.

Reset
REQ-027 While rst_ni = 0, the block SHALL force, independent of clk_i: state = IDLE, tx_o = 1, tx_ready_o = 1, busy_o = 0, done_o = 0, and all counters and the shift register = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with no done_o pulse; the first accepted request after release SHALL produce a complete, correct frame.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1)
REQ-029 Bench SHALL check: reset asserted -> tx_o=1, tx_ready_o=1, busy_o=0, done_o=0, including with clk_i stopped.
REQ-030 Bench SHALL check: send 0xA5 -> tx_o = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles (40 cycles total); done_o pulses once, in cycle 41 after acceptance.
REQ-031 Bench SHALL check: tx_valid_i=1 with 0xFF during a 0x3C frame, and tx_data_i altered after acceptance -> line carries 0x3C only; 0xFF is accepted only in the done_o cycle.
REQ-032 Bench SHALL check: tx_valid_i held high with 0x00 then 0xFF -> two frames with exactly one idle-high cycle between them; tx_ready_o high only in those IDLE cycles.
REQ-033 Bench SHALL check: rst_ni pulsed low at the 3rd data bit of 0x55 -> tx_o=1 immediately and no done_o; then a send of 0x81 after release -> correct 40-cycle frame.
REQ-034 Bench SHALL check: STOP_BITS=2 with 0xF0 -> stop level held 8 cycles and frame length 44 cycles.
